zone_color_acc: RTL
===================

ZONE_COLOR_ACC -- requirements
Module: zone_color_acc

Interface
REQ-001 Parameter CW, default 8: bits per colour channel; pixel and result words are 3*CW bits, ordered G,R,B from MSB.
REQ-002 Parameter ACC_W, default 16: accumulator width per channel; ACC_W SHALL be at least CW+4.
REQ-003 Parameter SH1, default 1: right-shift applied to tier-1 pixels.
REQ-004 Parameter SH2, default 4: right-shift applied to tier-2 pixels.
REQ-005 Parameter SH3, default 6: right-shift applied to tier-3 pixels.
REQ-006 Parameter MODE, default 0: 0 = clamped sum; 1 = average via shift.
REQ-007 Parameter NORM_SH, default 4: right-shift applied to the sum in MODE 1.
REQ-008 clk  in  1: single clock; all logic on its rising edge.
REQ-009 rst  in  1: reset, asynchronous, active-low.
REQ-010 frame_start  in  1: one-cycle pulse opening a frame.
REQ-011 frame_end  in  1: one-cycle pulse closing a frame.
REQ-012 pix_valid  in  1: pix_grb and pix_tier are valid this cycle.
REQ-013 pix_grb  in  3*CW: pixel colour.
REQ-014 pix_tier  in  2: zone tier from the external area decoder (0 = outside zone, 1..3 = tier).
REQ-015 result  out  3*CW: zone colour for the last completed frame.
REQ-016 result_valid  out  1: one-cycle pulse when result updates.
REQ-017 busy  out  1: high while in ACCUM or OUTPUT.
REQ-018 restart_err  out  1: one-cycle pulse when an open frame is abandoned.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM and OUTPUT.
REQ-020 IDLE to ACCUM on frame_start: clear all three accumulators and the pixel counter in the same edge.
REQ-021 In ACCUM, each cycle with pix_valid=1 and pix_tier!=0: acc_c += zero-extended (channel >> SHn), per channel independently.
REQ-022 Each accumulator SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-023 A 10-bit pixel counter SHALL increment per accepted pixel and saturate at 1023; it is internal, for verification only.
REQ-024 ACCUM to OUTPUT on frame_end; pix_valid in the same cycle as frame_end SHALL be accumulated.
REQ-025 In OUTPUT, MODE 0: result channel = min(acc, 2^CW-1).
REQ-026 In OUTPUT, MODE 1: result channel = min(acc >> NORM_SH, 2^CW-1).
REQ-027 In OUTPUT, result_valid=1 for exactly one cycle, then return to IDLE.
REQ-028 Latency: result and result_valid SHALL be registered one cycle after the frame_end edge.
REQ-029 result SHALL hold its value between updates; it SHALL never show partial sums.
REQ-030 frame_start in ACCUM: clear accumulators, stay in ACCUM, pulse restart_err for one cycle; result is unchanged.
REQ-031 frame_start and frame_end together in ACCUM: frame_end wins (go to OUTPUT); frame_start is ignored.
REQ-032 frame_start in OUTPUT SHALL be ignored.
REQ-033 frame_end in IDLE SHALL be ignored, and result_valid stays 0.
REQ-034 pix_valid outside ACCUM SHALL be ignored.
REQ-035 In IDLE, busy=0; busy=1 in ACCUM and OUTPUT.

Reset
REQ-036 On rst low, immediately: state IDLE; accumulators, counter, result, result_valid, busy and restart_err = 0.
REQ-037 Reset mid-frame SHALL discard the frame with no result_valid pulse.
REQ-038 Reset release SHALL be synchronised internally to clk before the FSM leaves IDLE.

Verification
REQ-039 Defaults, MODE 0: frame_start, 4 tier-1 pixels of 0x404040, frame_end -> one cycle later result=0x808080 and one result_valid pulse.
REQ-040 Mixed tiers: one pixel each of tier 1/2/3 (0xFF0000 each) plus one tier-0 pixel -> G = 127+15+3 = 145 (0x91); R and B = 0.
REQ-041 Saturation: 300 tier-1 pixels of 0xFFFFFF in MODE 0 -> result=0xFFFFFF; accumulator checked not wrapped.
REQ-042 MODE 1, NORM_SH=4: 16 tier-1 pixels of 0x202020 -> sum 256 per channel -> result=0x101010.
REQ-043 frame_start mid-frame -> restart_err pulse, old result held; next frame_end yields only post-restart pixels.
REQ-044 rst asserted during ACCUM -> all outputs 0 immediately, no result_valid; frame_end in IDLE afterwards -> no response.

Source files
------------

// File: rtl/zone_color_acc.sv
// Zone colour accumulator: sums tier-weighted pixel colours over a frame
// and publishes a clamped (or shift-averaged) G,R,B result at frame end.
module zone_color_acc #(
    parameter int CW      = 8,
    parameter int ACC_W   = 16,
    parameter int SH1     = 1,
    parameter int SH2     = 4,
    parameter int SH3     = 6,
    parameter int MODE    = 0,
    parameter int NORM_SH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            frame_end,
    input  logic            pix_valid,
    input  logic [3*CW-1:0] pix_grb,
    input  logic [1:0]      pix_tier,
    output logic [3*CW-1:0] result,
    output logic            result_valid,
    output logic            busy,
    output logic            restart_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

    localparam logic [ACC_W-1:0] CH_MAX = ACC_W'((1 << CW) - 1);

    state_t              state_q, state_d;
    logic [1:0]          rst_sync_q;
    logic                run_ok;
    logic [3*ACC_W-1:0]  acc_q, acc_d;
    logic [9:0]          cnt_q, cnt_d;
    logic [3*CW-1:0]     result_q, result_d, res_ch;
    logic                result_valid_q, result_valid_d;
    logic                restart_err_q, restart_err_d;
    logic                pix_acc, clear_acc;

    // Reset assertion is immediate; release is walked through two flops so
    // the FSM only starts a frame once the release is clean in this domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign run_ok = rst_sync_q[1];

    // A restart (frame_start without frame_end) discards the same-cycle pixel
    // along with everything accumulated so far.
    assign pix_acc   = (state_q == S_ACCUM) && pix_valid && (pix_tier != 2'd0)
                       && !(frame_start && !frame_end);
    assign clear_acc = ((state_q == S_IDLE) && run_ok && frame_start)
                       || ((state_q == S_ACCUM) && frame_start && !frame_end);

    // Per-channel saturating accumulator and output clamp; the clamp reads the
    // next-state value so a pixel arriving with frame_end is included.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [CW-1:0]    chan, shifted;
        logic [ACC_W:0]   sum;
        logic [ACC_W-1:0] acc_cur, acc_new, normed;

        assign chan    = pix_grb[gi*CW +: CW];
        assign shifted = (pix_tier == 2'd1) ? (chan >> SH1) :
                         (pix_tier == 2'd2) ? (chan >> SH2) : (chan >> SH3);
        assign acc_cur = acc_q[gi*ACC_W +: ACC_W];
        assign sum     = {1'b0, acc_cur} + {{(ACC_W+1-CW){1'b0}}, shifted};

        // Next accumulator value: clear, saturating add, or hold.
        always_comb begin
            acc_new = acc_cur;
            if (clear_acc)    acc_new = '0;
            else if (pix_acc) acc_new = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end

        assign acc_d[gi*ACC_W +: ACC_W] = acc_new;
        assign normed = (MODE == 1) ? (acc_new >> NORM_SH) : acc_new;
        assign res_ch[gi*CW +: CW] = (normed > CH_MAX) ? {CW{1'b1}} : normed[CW-1:0];
    end

    // Accepted-pixel counter, saturating at 1023; cleared with the accumulators.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_acc)                      cnt_d = '0;
        else if (pix_acc && cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
    end

    // Next-state and output pulse decode; frame_end takes priority over a
    // simultaneous frame_start while accumulating.
    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        restart_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_ok && frame_start) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (frame_end) begin
                    state_d        = S_OUTPUT;
                    result_d       = res_ch;
                    result_valid_d = 1'b1;
                end else if (frame_start) begin
                    restart_err_d  = 1'b1;
                end
            end
            S_OUTPUT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            restart_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            restart_err_q  <= restart_err_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign restart_err  = restart_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule
